// File: rtl/unidade_controle_rodadas_if.sv
// ---------------------------------------------------------------------------
// unidade_controle_rodadas_if
//
// Bundles the signals exchanged between the round-mode control unit and the
// memory-game datapath. clock and reset are not part of the bundle.
//
//   master : the control unit. It drives the datapath controls (zeraE,
//            contaE, zeraL, contaL, zeraR, registraR), the game status
//            (pronto, acertou, errou, timeout) and db_estado. It samples
//            iniciar, jogada, igual, fimE and fimL.
//   slave  : the datapath / top-level side, with the opposite directions.
// ---------------------------------------------------------------------------
interface unidade_controle_rodadas_if;
  // Status and requests into the control unit
  logic       iniciar;
  logic       jogada;
  logic       igual;
  logic       fimE;
  logic       fimL;
  // Datapath controls
  logic       zeraE;
  logic       contaE;
  logic       zeraL;
  logic       contaL;
  logic       zeraR;
  logic       registraR;
  // Game status
  logic       pronto;
  logic       acertou;
  logic       errou;
  logic       timeout;
  logic [3:0] db_estado;

  modport master (
    input  iniciar, jogada, igual, fimE, fimL,
    output zeraE, contaE, zeraL, contaL, zeraR, registraR,
    output pronto, acertou, errou, timeout, db_estado
  );

  modport slave (
    output iniciar, jogada, igual, fimE, fimL,
    input  zeraE, contaE, zeraL, contaL, zeraR, registraR,
    input  pronto, acertou, errou, timeout, db_estado
  );
endinterface

// File: rtl/unidade_controle_rodadas.sv
// ---------------------------------------------------------------------------
// unidade_controle_rodadas
//
// Moore control unit for the memory game in round mode. Each round replays
// positions 0..limit. The limit grows by one per completed round until the
// final round has been played. A cycle timer bounds the wait for each play.
//
// Ports:
//   clock : system clock. All state updates happen on the rising edge.
//   reset : synchronous, active-high. Returns the unit to INICIAL and clears
//           the timer.
//   bus   : unidade_controle_rodadas_if.master. Carries the datapath
//           controls, the game status, db_estado and the inputs
//           iniciar/jogada/igual/fimE/fimL.
//
// Parameter:
//   TIMEOUT_CICLOS : cycles allowed in ESPERA without a play (>= 2).
// ---------------------------------------------------------------------------
module unidade_controle_rodadas #(
  parameter int TIMEOUT_CICLOS = 5000
) (
  input  logic                       clock,
  input  logic                       reset,
  unidade_controle_rodadas_if.master bus
);

  localparam int              TW = $clog2(TIMEOUT_CICLOS);
  localparam logic [TW-1:0]   TC = TW'(TIMEOUT_CICLOS - 1);

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    ESPERA         = 4'h2,
    REGISTRA       = 4'h4,
    COMPARA        = 4'h5,
    PROXIMA        = 4'h6,
    PROXIMA_RODADA = 4'h7,
    FIM_ACERTO     = 4'hA,
    FIM_TIMEOUT    = 4'hD,
    FIM_ERRO       = 4'hE
  } estado_t;

  typedef struct packed {
    logic zeraE;
    logic contaE;
    logic zeraL;
    logic contaL;
    logic zeraR;
    logic registraR;
    logic pronto;
    logic acertou;
    logic errou;
    logic timeout;
  } saidas_t;

  estado_t       estado;
  estado_t       estado_prox;
  saidas_t       saidas;
  logic [TW-1:0] timer;
  logic          timer_fim;

  assign timer_fim = (timer == TC);

  // Moore output decode. It is applied to the next state, so the registered
  // outputs always match the state register.
  function automatic saidas_t decodifica(input estado_t e);
    saidas_t s;
    s = '0;
    case (e)
      PREPARACAO:     begin s.zeraE = 1'b1; s.zeraL = 1'b1; s.zeraR = 1'b1; end
      REGISTRA:       s.registraR = 1'b1;
      PROXIMA:        s.contaE = 1'b1;
      PROXIMA_RODADA: begin s.contaL = 1'b1; s.zeraE = 1'b1; end
      FIM_ACERTO:     begin s.pronto = 1'b1; s.acertou = 1'b1; end
      FIM_ERRO:       begin s.pronto = 1'b1; s.errou = 1'b1; end
      FIM_TIMEOUT:    begin s.pronto = 1'b1; s.errou = 1'b1; s.timeout = 1'b1; end
      default:        s = '0;
    endcase
    return s;
  endfunction

  always_comb begin
    // NOTE: default first, so no path through the case can infer a latch.
    estado_prox = estado;
    case (estado)
      INICIAL:        if (bus.iniciar) estado_prox = PREPARACAO;
      PREPARACAO:     estado_prox = ESPERA;
      ESPERA: begin
        // A play on the terminal-count cycle takes priority over timeout.
        if (bus.jogada)     estado_prox = REGISTRA;
        else if (timer_fim) estado_prox = FIM_TIMEOUT;
      end
      REGISTRA:       estado_prox = COMPARA;
      COMPARA: begin
        if (!bus.igual)     estado_prox = FIM_ERRO;
        else if (!bus.fimE) estado_prox = PROXIMA;
        else if (bus.fimL)  estado_prox = FIM_ACERTO;
        else                estado_prox = PROXIMA_RODADA;
      end
      PROXIMA:        estado_prox = ESPERA;
      PROXIMA_RODADA: estado_prox = ESPERA;
      FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT:
                      if (bus.iniciar) estado_prox = PREPARACAO;
      default:        estado_prox = INICIAL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= INICIAL;
      timer  <= '0;
      saidas <= '0;
    end else begin
      estado <= estado_prox;
      saidas <= decodifica(estado_prox);
      // The timer counts only while the unit stays in ESPERA. Any exit,
      // including the one at terminal count, clears it, so it never wraps
      // and every new entry to ESPERA starts from zero.
      if (estado == ESPERA && estado_prox == ESPERA) timer <= timer + 1'b1;
      else                                           timer <= '0;
    end
  end

  assign bus.zeraE     = saidas.zeraE;
  assign bus.contaE    = saidas.contaE;
  assign bus.zeraL     = saidas.zeraL;
  assign bus.contaL    = saidas.contaL;
  assign bus.zeraR     = saidas.zeraR;
  assign bus.registraR = saidas.registraR;
  assign bus.pronto    = saidas.pronto;
  assign bus.acertou   = saidas.acertou;
  assign bus.errou     = saidas.errou;
  assign bus.timeout   = saidas.timeout;
  assign bus.db_estado = estado;

endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// ---------------------------------------------------------------------------
// tb_unidade_controle_rodadas
//
// Directed bench for unidade_controle_rodadas with TIMEOUT_CICLOS = 10.
// Inputs change 1 ns after each rising edge. Outputs are sampled at the same
// point, after the next rising edge has taken effect.
// The output vector is
// {zeraE, contaE, zeraL, contaL, zeraR, registraR, pronto, acertou, errou, timeout}.
// ---------------------------------------------------------------------------
module tb_unidade_controle_rodadas;

  localparam int TO = 10;

  localparam logic [9:0] O_NADA   = 10'b00000_00000;
  localparam logic [9:0] O_PREP   = 10'b10101_00000;
  localparam logic [9:0] O_REG    = 10'b00000_10000;
  localparam logic [9:0] O_PROX   = 10'b01000_00000;
  localparam logic [9:0] O_PROXR  = 10'b10010_00000;
  localparam logic [9:0] O_ACERTO = 10'b00000_01100;
  localparam logic [9:0] O_ERRO   = 10'b00000_01010;
  localparam logic [9:0] O_TO     = 10'b00000_01011;

  logic clock;
  logic reset;
  unidade_controle_rodadas_if bus ();

  unidade_controle_rodadas #(.TIMEOUT_CICLOS(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests;
  int fails;

  typedef struct {
    logic       reset;
    logic       iniciar;
    logic       jogada;
    logic       igual;
    logic       fimE;
    logic       fimL;
    logic [3:0] est;
    logic [9:0] outs;
  } vetor_t;

  vetor_t tbl [17];

  function automatic logic [9:0] saidas();
    return {bus.zeraE, bus.contaE, bus.zeraL, bus.contaL, bus.zeraR,
            bus.registraR, bus.pronto, bus.acertou, bus.errou, bus.timeout};
  endfunction

  task automatic check(input string nome, input logic [31:0] atual,
                       input logic [31:0] esperado);
    tests++;
    if (atual !== esperado) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nome, atual, esperado);
    end
  endtask

  task automatic passo();
    @(posedge clock);
    #1;
  endtask

  task automatic check_estado(input string nome, input logic [3:0] est,
                              input logic [9:0] outs);
    check({nome, " estado"}, 32'(bus.db_estado), 32'(est));
    check({nome, " saidas"}, 32'(saidas()), 32'(outs));
  endtask

  task automatic entradas(input logic i, input logic j, input logic g,
                          input logic e, input logic l);
    bus.iniciar = i; bus.jogada = j; bus.igual = g; bus.fimE = e; bus.fimL = l;
  endtask

  // One play from ESPERA: jogada edge -> REGISTRA, then COMPARA.
  task automatic jogar(input string nome, input logic g, input logic e,
                       input logic l);
    entradas(1'b0, 1'b1, g, e, l);
    passo();
    check_estado({nome, " registra"}, 4'h4, O_REG);
    bus.jogada = 1'b0;
    passo();
    check_estado({nome, " compara"}, 4'h5, O_NADA);
  endtask

  // From an end state: iniciar -> PREPARACAO -> ESPERA (entry edge).
  task automatic reiniciar(input string nome);
    entradas(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    passo();
    check_estado({nome, " prep"}, 4'h1, O_PREP);
    bus.iniciar = 1'b0;
    passo();
    check_estado({nome, " espera"}, 4'h2, O_NADA);
  endtask

  initial begin
    tests = 0;
    fails = 0;

    // reset, iniciar, jogada, igual, fimE, fimL, estado, saidas
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'h0, O_NADA};   // reset, noisy inputs
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'h0, O_NADA};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, O_PREP};   // start
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2, O_NADA};   // zera* lasted 1 cycle
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h4, O_REG};    // round 0 play
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h5, O_NADA};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h7, O_PROXR};  // next round
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2, O_NADA};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h4, O_REG};    // round 1 play 1
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h5, O_NADA};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h6, O_PROX};   // next position
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2, O_NADA};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h4, O_REG};    // round 1 play 2
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h5, O_NADA};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'hA, O_ACERTO}; // win
    tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hA, O_ACERTO}; // jogada ignored
    tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, O_PREP};   // restart

    reset = 1'b1;
    entradas(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;

    for (int i = 0; i < 17; i++) begin
      reset = tbl[i].reset;
      entradas(tbl[i].iniciar, tbl[i].jogada, tbl[i].igual, tbl[i].fimE, tbl[i].fimL);
      passo();
      check_estado($sformatf("vetor%0d", i), tbl[i].est, tbl[i].outs);
    end

    // Wrong play: second play of round 1 with igual=0.
    bus.iniciar = 1'b0;
    passo();
    check_estado("erro entra", 4'h2, O_NADA);
    jogar("erro r0", 1'b1, 1'b1, 1'b0);
    passo();
    check_estado("erro r0 proxr", 4'h7, O_PROXR);
    passo();
    jogar("erro r1p1", 1'b1, 1'b0, 1'b1);
    passo();
    check_estado("erro r1p1 prox", 4'h6, O_PROX);
    passo();
    jogar("erro r1p2", 1'b0, 1'b1, 1'b1);
    passo();
    check_estado("fim erro", 4'hE, O_ERRO);
    passo();
    check_estado("fim erro hold", 4'hE, O_ERRO);

    // Restart from FIM_ERRO: full timeout budget, timeout at exactly cycle 10.
    reiniciar("to");
    for (int c = 1; c < TO; c++) begin
      passo();
      check_estado($sformatf("to ciclo%0d", c), 4'h2, O_NADA);
    end
    passo();
    check_estado("fim timeout", 4'hD, O_TO);

    // Play on the terminal-count cycle wins over timeout.
    reiniciar("tc");
    for (int c = 1; c < TO; c++) passo();
    check_estado("tc antes", 4'h2, O_NADA);
    jogar("tc", 1'b1, 1'b0, 1'b0);

    // Reset while in COMPARA.
    reset = 1'b1;
    passo();
    check_estado("reset compara", 4'h0, O_NADA);
    reset = 1'b0;
    entradas(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    passo();
    check_estado("jogada inicial", 4'h0, O_NADA);
    bus.jogada = 1'b0;
    passo();
    check_estado("inicial hold", 4'h0, O_NADA);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/unidade_controle_rodadas.md
# unidade_controle_rodadas

Moore control unit that sequences the memory-game datapath in round mode. Each round replays positions 0..limit; the limit grows by one per completed round until the last round. It drives the position counter (E), the limit counter (L) and the play register (R). It also enforces a per-play timeout with an internal cycle counter. It sits beside the datapath inside the game top level and replaces the single-pass control unit.

## Interface
Parameters:
- TIMEOUT_CICLOS, default 5000: cycles allowed in ESPERA without a play before timeout; legal range ≥ 2.

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; forces INICIAL and clears timer on next edge
- iniciar  in  1  start/restart request, level-sampled
- jogada  in  1  one-cycle pulse from datapath edge detector: a key was pressed
- igual  in  1  datapath comparator: registered play == memory[E]
- fimE  in  1  datapath: E == L (last position of current round)
- fimL  in  1  datapath: L == final limit (last round)
- zeraE  out  1  synchronous clear of position counter
- contaE  out  1  increment position counter
- zeraL  out  1  synchronous clear of limit counter
- contaL  out  1  increment limit counter
- zeraR  out  1  clear play register
- registraR  out  1  load play register from keys
- pronto  out  1  game finished (any outcome)
- acertou  out  1  game won
- errou  out  1  game lost (wrong play or timeout)
- timeout  out  1  game lost by timeout
- db_estado  out  4  current state code, for the 7-seg debug display

## Operation
- All outputs are Moore, decoded from state only. Any output not listed for a state is 0.
- INICIAL (4'h0): outputs all 0. iniciar=1 → PREPARACAO.
- PREPARACAO (4'h1): zeraE=zeraL=zeraR=1, timer cleared. → ESPERA.
- ESPERA (4'h2): timer increments each cycle.
  - jogada=1 → REGISTRA.
  - Else if timer == TIMEOUT_CICLOS-1 → FIM_TIMEOUT.
  - Else stay.
- REGISTRA (4'h4): registraR=1, timer cleared. → COMPARA.
- COMPARA (4'h5): conditions are checked in this priority order:
  - igual=0 → FIM_ERRO.
  - Else fimE=0 → PROXIMA.
  - Else fimL=1 → FIM_ACERTO.
  - Else → PROXIMA_RODADA.
- PROXIMA (4'h6): contaE=1. → ESPERA.
- PROXIMA_RODADA (4'h7): contaL=1, zeraE=1. → ESPERA.
- FIM_ACERTO (4'hA): pronto=acertou=1.
- FIM_ERRO (4'hE): pronto=errou=1.
- FIM_TIMEOUT (4'hD): pronto=errou=timeout=1.
- In all three end states: iniciar=1 → PREPARACAO; else hold.
- Unused state codes → INICIAL on next edge.
- Timer:
  - Width is $clog2(TIMEOUT_CICLOS).
  - Counts only while in ESPERA.
  - Held at 0 in every other state, so it restarts from 0 on every entry to ESPERA.
  - Never wraps: it leaves ESPERA at its terminal count.

## Timing
- Reset: on the edge with reset=1, state=INICIAL and timer=0, so db_estado=4'h0. All other outputs are 0 from that edge on. reset has priority over every input, including mid-round.
- Start latency: iniciar sampled high at edge t (in INICIAL or an end state) puts the block in PREPARACAO after t and in ESPERA after t+1.
- Play path: jogada at edge t in ESPERA is followed by REGISTRA (t+1), then COMPARA (t+2), then PROXIMA/PROXIMA_RODADA/end state (t+3). ESPERA is re-entered at t+4.
- registraR is asserted one full cycle before COMPARA, so igual is valid when sampled.
- Timeout:
  - Entering ESPERA at edge t with no jogada for TIMEOUT_CICLOS consecutive samples gives FIM_TIMEOUT at edge t+TIMEOUT_CICLOS.
  - jogada on the terminal-count cycle wins: the next state is REGISTRA, not timeout.
- jogada is ignored outside ESPERA. iniciar is ignored outside INICIAL and the end states.
- contaE and contaL are one-cycle pulses. zeraE and contaL are never both active with contaE.

## Test plan
- Reset: TIMEOUT_CICLOS=10. Hold reset 2 cycles with random inputs → db_estado=0, all control and status outputs 0. Release reset, assert iniciar 1 cycle → db_estado goes 1 then 2, zeraE/zeraL/zeraR high exactly 1 cycle.
- Full win, 2 rounds:
  - Round 0: igual=1, fimE=1, fimL=0 → 1 play, then PROXIMA_RODADA (contaL and zeraE pulse).
  - Round 1: 2 plays, fimE=0 then 1, fimL=1 → PROXIMA once, then FIM_ACERTO.
  - Expected: db_estado=A, pronto=acertou=1, errou=0.
- Wrong play: 2nd play of round 1 with igual=0 → FIM_ERRO (db_estado=E), pronto=errou=1, timeout=0, no contaE pulse after COMPARA.
- Timeout, TIMEOUT_CICLOS=10:
  - No jogada for 10 cycles after entering ESPERA → FIM_TIMEOUT at exactly cycle 10, db_estado=D, errou=timeout=pronto=1.
  - Repeat with jogada on cycle 10 (the terminal-count cycle) → REGISTRA, no timeout.
- Restart and mid-game reset:
  - From FIM_ERRO, iniciar=1 → PREPARACAO and the timer is clear: a full 10-cycle budget applies again.
  - reset asserted while in COMPARA → INICIAL next edge, outputs 0.
  - Stray jogada in INICIAL → no state change.
